// File: rtl/edge_pkg.sv
// Shared Sobel kernel constants plus width and saturation helpers for the streaming edge detector.
package edge_pkg;

   // Kernels are indexed [row][column], with row 0 at the top of the window.
   localparam int SOBEL_GX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
   localparam int SOBEL_GY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

   function automatic int gradWidth(input int pixW);
      return pixW + 3;
   endfunction

   function automatic int magWidth(input int pixW);
      return pixW + 2;
   endfunction

   function automatic int saturate(input int value, input int maxVal);
      return (value > maxVal) ? maxVal : value;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line RAM with a combinational read, so a write in the same cycle sees the old word.
// One cycle to write; it has no handshake because the owner gates wrEn.
module sobel_line_buffer #(
   parameter int DEPTH  = 100,
   parameter int WIDTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wrDat,
   output logic [WIDTH-1:0]  rdDat
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdDat = mem[addr];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[addr] <= wrDat;
      end
   end

endmodule

// File: rtl/sobel_stream_edge.sv
// Streaming 3x3 Sobel L1 magnitude over a raster pixel stream with one output register; the pipeline stalls whole when it is full.
// EDGE_THRESHOLD_EN swaps the saturated magnitude for a binary edge map compared against THRESH.
module sobel_stream_edge
   import edge_pkg::*;
#(
   parameter int IMG_W  = 100,
   parameter int IMG_H  = 100,
   parameter int PIX_W  = 8,
   parameter int THRESH = 128
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [PIX_W-1:0] in_pix_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [PIX_W-1:0] out_pix_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             out_last_o
);

   localparam int XW      = $clog2(IMG_W);
   localparam int YW      = $clog2(IMG_H);
   localparam int GW      = gradWidth(PIX_W);
   localparam int MW      = magWidth(PIX_W);
   localparam int PIX_MAX = (1 << PIX_W) - 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   if (IMG_W < 3 || IMG_H < 3 || THRESH < 0) begin : gBadParams
      $error("sobel_stream_edge: frame must be at least 3x3 and THRESH non-negative");
   end

   logic [XW-1:0]    colCnt;
   logic [YW-1:0]    rowCnt;
   logic             inFire;
   logic             winDone;
   logic             frameEnd;
   logic [PIX_W-1:0] rowAbove;
   logic [PIX_W-1:0] rowTwoAbove;
   logic [PIX_W-1:0] win  [3][2];
   logic [PIX_W-1:0] taps [3][3];
   int               accX;
   int               accY;
   logic signed [GW-1:0] gradX;
   logic signed [GW-1:0] gradY;
   logic [GW-1:0]    absX;
   logic [GW-1:0]    absY;
   logic [GW-1:0]    absSum;
   logic [MW-1:0]    mag;
   logic [PIX_W-1:0] edgePix;

   assign in_ready_o = rst_i && (!out_valid_o || out_ready_i);
   assign inFire     = in_valid_i && in_ready_o;
   assign winDone    = (colCnt >= XW'(2)) && (rowCnt >= YW'(2));
   assign frameEnd   = (colCnt == X_LAST) && (rowCnt == Y_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         colCnt <= '0;
         rowCnt <= '0;
      end else if (inFire) begin
         if (colCnt == X_LAST) begin
            colCnt <= '0;
            rowCnt <= (rowCnt == Y_LAST) ? '0 : rowCnt + YW'(1);
         end else begin
            colCnt <= colCnt + XW'(1);
         end
      end
   end

   // Both history rows share one word: the current pixel moves into the y-1 half, old y-1 into the y-2 half.
   sobel_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (2 * PIX_W),
      .ADDR_W(XW)
   ) uLineBuf (
      .clk  (clk_i),
      .wrEn (inFire),
      .addr (colCnt),
      .wrDat({in_pix_i, rowAbove}),
      .rdDat({rowAbove, rowTwoAbove})
   );

   // Only the two older columns are stored; the newest column comes straight from the buffers and input.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         taps[r][0] = win[r][0];
         taps[r][1] = win[r][1];
      end
      taps[0][2] = rowTwoAbove;
      taps[1][2] = rowAbove;
      taps[2][2] = in_pix_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= '0;
            win[r][1] <= '0;
         end
      end else if (inFire) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= taps[r][1];
            win[r][1] <= taps[r][2];
         end
      end
   end

   always_comb begin
      accX = 0;
      accY = 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            accX += SOBEL_GX[r][c] * int'(taps[r][c]);
            accY += SOBEL_GY[r][c] * int'(taps[r][c]);
         end
      end
      gradX = GW'(accX);
      gradY = GW'(accY);
   end

   // |G| never exceeds 4*PIX_MAX, so the absolute values and their sum still fit in GW unsigned bits.
   assign absX   = gradX[GW-1] ? $unsigned(-gradX) : $unsigned(gradX);
   assign absY   = gradY[GW-1] ? $unsigned(-gradY) : $unsigned(gradY);
   assign absSum = absX + absY;
   assign mag    = MW'(absSum >> 1);

`ifdef EDGE_THRESHOLD_EN
   assign edgePix = (int'(mag) >= THRESH) ? PIX_W'(PIX_MAX) : '0;
`else
   assign edgePix = PIX_W'(saturate(int'(mag), PIX_MAX));
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_valid_o <= 1'b0;
         out_pix_o   <= '0;
         out_last_o  <= 1'b0;
      end else if (inFire && winDone) begin
         out_valid_o <= 1'b1;
         out_pix_o   <= edgePix;
         out_last_o  <= frameEnd;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
         out_last_o  <= 1'b0;
      end
   end

endmodule

// File: doc/sobel_stream_edge.md
# sobel_stream_edge

Streaming, parametrised successor to the frame-buffered edge-detector datapath. Consumes a raster-order grayscale pixel stream over a valid/ready handshake. Keeps only two line buffers plus a 3x3 window instead of full-frame Img/Gx/Gy memories. Emits the L1 Sobel magnitude of every interior pixel on a valid/ready output stream with a one-cycle pipeline.

## Interface
- IMG_W, default 100: frame width in pixels, ≥3
- IMG_H, default 100: frame height in pixels, ≥3
- PIX_W, default 8: pixel width, input and output
- THRESH, default 128: binarisation threshold (used only with EDGE_THRESHOLD_EN)
- clk_i  in  1: clock, rising edge
- rst_i  in  1: asynchronous, active-low reset
- in_pix_i  in  PIX_W: input pixel
- in_valid_i  in  1: input pixel valid
- in_ready_o  out  1: block accepts input this cycle
- out_pix_o  out  PIX_W: edge magnitude
- out_valid_o  out  1: out_pix_o valid
- out_ready_i  in  1: downstream accepts
- out_last_o  out  1: qualifies the last interior pixel of a frame, (IMG_W-2, IMG_H-2)

## Operation
- Input transfer: in_valid_i && in_ready_o. Output transfer: out_valid_o && out_ready_i.
- Column counter x ∈ [0, IMG_W-1] and row counter y ∈ [0, IMG_H-1] advance on each input transfer.
  - x wraps to 0 and increments y.
  - After (IMG_W-1, IMG_H-1), both wrap to 0. The next pixel starts a new frame; no idle gap is required.
- Two line buffers, IMG_W × PIX_W each, hold rows y-1 and y-2.
  - On an input transfer at column x: read both at x, write the current pixel into row y-1's slot at x, and shift the old row y-1 value into row y-2's slot.
  - Read-before-write at the same address.
- 3x3 window: three columns of three taps, rows y-2, y-1, y. It shifts left on every input transfer. Contents at x=0, 1 are don't-care.
- Window completion: a transfer at x≥2 and y≥2 completes the window centred at (x-1, y-1). It produces exactly one output. Others produce none.
  - Each frame therefore yields (IMG_W-2)·(IMG_H-2) outputs in raster order.
- Arithmetic, rows top→bottom:
  - Gx = [-1 0 1; -2 0 2; -1 0 1]
  - Gy = [-1 -2 -1; 0 0 0; 1 2 1]
  - Gx and Gy are signed, PIX_W+3 bits, exact (|G| ≤ 4·(2^PIX_W-1)).
  - mag = (|Gx| + |Gy|) >> 1, PIX_W+2 bits.
  - out_pix_o = min(mag, 2^PIX_W-1), saturating with no wrap.
- Output register: one stage holding pix/last.
- Ready: in_ready_o = !out_valid_o || out_ready_i, and is forced to 0 while rst_i is low.
  - An input producing an output can therefore only be taken when the register is free or draining.
  - Non-producing inputs follow the same rule; the pipeline stalls as a whole.
- Reset mid-frame: counters, window, and output register clear. Line buffer contents are not cleared. The next accepted pixel is treated as (0,0).

## Timing
- Reset values: out_valid_o=0, out_last_o=0, out_pix_o=0, in_ready_o=0 during reset and 1 on the first cycle after release.
- Latency: an output is registered on the clock edge of the completing input transfer. out_valid_o is high on the following cycle.
- out_valid_o/out_pix_o/out_last_o stay stable while out_valid_o && !out_ready_i.
- Simultaneous output transfer and new completing input: the register reloads in the same edge, so out_valid_o stays 1. Full throughput is 1 pixel/cycle.
- Output transfer with no new completing input: out_valid_o falls next cycle.
- in_valid_i may toggle freely. in_pix_i is sampled only on transfer.

## Configuration
- EDGE_THRESHOLD_EN defined: out_pix_o = (mag ≥ THRESH) ? 2^PIX_W-1 : 0, a binary edge map. Comparison uses the unsaturated mag.
- Undefined: saturated magnitude as above; THRESH unused.
- Timing and handshake are identical in both builds.

## Structure
- Shared package edge_pkg:
  - Sobel coefficient constants
  - width functions: G width PIX_W+3, magnitude width PIX_W+2
  - the saturate helper
- Sub-module sobel_line_buffer: a single-port IMG_W-deep RAM with read-before-write and a $clog2(IMG_W) address. Instantiated twice, or once with a 2·PIX_W word.
- Top level: counters, window shift register, combinational Sobel/abs/sum, output register.

## Test plan
- 5×5, PIX_W=8, columns 0–1 = 0 and columns 2–4 = 100, streamed continuously with out_ready_i=1 -> 9 outputs, rows each 200, 200, 0; out_last_o only on the 9th.
- 5×5 constant 77 -> 9 outputs, all 0; next frame back-to-back -> another 9 outputs, correct out_last_o.
- 5×5, rows 0–1 = 0 and rows 2–4 = 255 -> first row of outputs = 255 (mag 510 saturated); EDGE_THRESHOLD_EN build with THRESH=128 -> 255 for 510, 0 for mag 0.
- Step frame with out_ready_i held low for 4 cycles mid-stream -> in_ready_o drops, out_pix_o stable, output sequence identical to the no-stall run.
- Random in_valid_i gaps (50%) plus random out_ready_i on a 100×100 random image -> output matches reference model bit-exactly, count 9604.
- rst_i pulsed low after 13 pixels, then a full 5×5 step frame -> outputs 0 during reset; 9 correct outputs follow with no residue from the partial frame.
